// File: rtl/layer1_sequencer_if.sv
// Handshake and control bundle between the layer controller, the layer-1
// sequencer and the layer-1 datapath (weight ROM, picture ROM, enables).
interface layer1_sequencer_if #(
    parameter int ADDR_W = 14
) ();
    logic              start;
    logic              load_wt;
    logic [ADDR_W-1:0] img_base;
    logic              busy;
    logic              done;
    logic              wt_rd;
    logic [5:0]        wt_addr;
    logic              wt_we;
    logic [5:0]        wt_idx;
    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_vld;
    logic              conv_en;
    logic              pool_buf_en;
    logic              pool_en;
    logic [7:0]        pool_idx;

    // Controller / stimulus side
    modport master (
        output start, load_wt, img_base,
        input  busy, done, wt_rd, wt_addr, wt_we, wt_idx, pix_rd, pix_addr,
               pix_vld, conv_en, pool_buf_en, pool_en, pool_idx
    );

    // Sequencer side
    modport slave (
        input  start, load_wt, img_base,
        output busy, done, wt_rd, wt_addr, wt_we, wt_idx, pix_rd, pix_addr,
               pix_vld, conv_en, pool_buf_en, pool_en, pool_idx
    );
endinterface

// File: rtl/layer1_sequencer.sv
// Layer-1 sequencer: optional weight load, one-pixel-per-cycle image stream,
// and conv / pooling enables derived from per-pixel row/column tags carried
// down shift registers matched to the datapath latencies.
module layer1_sequencer #(
    parameter int IMG_W    = 30,
    parameter int IMG_H    = 30,
    parameter int K        = 3,
    parameter int NUM_WT   = 60,
    parameter int ADDR_W   = 14,
    parameter int RD_LAT   = 1,
    parameter int BUF_LAT  = 1,
    parameter int CONV_LAT = 1,
    parameter int POOL_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    layer1_sequencer_if.slave  bus
);
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CONV_D = RD_LAT + BUF_LAT;
    localparam int POOL_D = CONV_D + CONV_LAT + POOL_LAT;
    localparam int POOL_N = ((IMG_W - K + 1) / 2) * ((IMG_H - K + 1) / 2);

    localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_FIRST   = CW'(K - 1);
    localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_FIRST   = RW'(K - 1);
    localparam logic [5:0]    WT_LAST   = 6'(NUM_WT - 1);
    localparam logic [7:0]    POOL_LAST = 8'(POOL_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [RW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    logic                wt_rd_q, wt_rd_d;
    logic [5:0]          wt_addr_q, wt_addr_d;
    logic                pix_rd_q, pix_rd_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          pool_idx_q, pool_idx_d;

    // Latency-matching shift registers (stage 0 is one cycle behind its source)
    logic [RD_LAT-1:0]          vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]          we_sr_q, we_sr_d;
    logic [RD_LAT-1:0][5:0]     idx_sr_q, idx_sr_d;
    logic [CONV_D-1:0]          conv_sr_q, conv_sr_d;
    logic [CONV_LAT-1:0]        pbuf_sr_q, pbuf_sr_d;
    logic [POOL_D-1:0]          pool_sr_q, pool_sr_d;

    logic [RD_LAT:0]            vld_tmp_s, we_tmp_s;
    logic [RD_LAT:0][5:0]       idx_tmp_s;
    logic [CONV_D:0]            conv_tmp_s;
    logic [CONV_LAT:0]          pbuf_tmp_s;
    logic [POOL_D:0]            pool_tmp_s;

    logic [RW-1:0]  orow_s;
    logic [CW-1:0]  ocol_s;
    logic           tag_s, odd_s, pool_next_s, last_pix_s;
    logic [7:0]     pool_cnt_s;

    // Per-pixel tags: inside the valid conv window, and at an odd output coordinate
    always_comb begin
        orow_s      = r_q - R_FIRST;
        ocol_s      = c_q - C_FIRST;
        tag_s       = pix_rd_q && (r_q >= R_FIRST) && (c_q >= C_FIRST);
        odd_s       = tag_s && orow_s[0] && ocol_s[0];
        last_pix_s  = (r_q == R_LAST) && (c_q == C_LAST);
        pool_cnt_s  = pool_idx_q + {7'd0, pool_sr_q[POOL_D-1]};
    end

    // Tag and ROM-latency shift registers advance one stage every cycle
    always_comb begin
        vld_tmp_s  = {vld_sr_q, pix_rd_q};
        we_tmp_s   = {we_sr_q, wt_rd_q};
        idx_tmp_s  = {idx_sr_q, wt_addr_q};
        conv_tmp_s = {conv_sr_q, tag_s};
        pbuf_tmp_s = {pbuf_sr_q, conv_sr_q[CONV_D-1]};
        pool_tmp_s = {pool_sr_q, odd_s};
        vld_sr_d   = vld_tmp_s[RD_LAT-1:0];
        we_sr_d    = we_tmp_s[RD_LAT-1:0];
        idx_sr_d   = idx_tmp_s[RD_LAT-1:0];
        conv_sr_d  = conv_tmp_s[CONV_D-1:0];
        pbuf_sr_d  = pbuf_tmp_s[CONV_LAT-1:0];
        pool_sr_d  = pool_tmp_s[POOL_D-1:0];
        pool_next_s = pool_sr_d[POOL_D-1];
    end

    // FSM next state, ROM addressing, pixel row/column counters and done
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        r_d        = r_q;
        c_d        = c_q;
        wt_rd_d    = 1'b0;
        wt_addr_d  = 6'd0;
        pix_rd_d   = 1'b0;
        pix_addr_d = {ADDR_W{1'b0}};
        done_d     = 1'b0;
        pool_idx_d = pool_cnt_s;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d     = bus.img_base;
                    r_d        = {RW{1'b0}};
                    c_d        = {CW{1'b0}};
                    pool_idx_d = 8'd0;
                    if (bus.load_wt) begin
                        state_d   = S_LOAD;
                        wt_rd_d   = 1'b1;
                    end else begin
                        state_d    = S_STREAM;
                        pix_rd_d   = 1'b1;
                        pix_addr_d = bus.img_base;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (wt_addr_q == WT_LAST) begin
                    state_d    = S_STREAM;
                    pix_rd_d   = 1'b1;
                    pix_addr_d = base_q;
                end else begin
                    wt_rd_d   = 1'b1;
                    wt_addr_d = wt_addr_q + 6'd1;
                end
            end
            S_STREAM: begin
                if (last_pix_s) begin
                    state_d = S_DRAIN;
                end else begin
                    pix_rd_d   = 1'b1;
                    pix_addr_d = pix_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (c_q == C_LAST) begin
                        c_d = {CW{1'b0}};
                        r_d = (r_q == R_LAST) ? r_q : r_q + {{(RW-1){1'b0}}, 1'b1};
                    end else begin
                        c_d = c_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DRAIN: begin
                // done rides with the final pool_en; IDLE follows once it has been issued
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (pool_next_s && (pool_cnt_s == POOL_LAST)) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; asynchronous abort on rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= {ADDR_W{1'b0}};
            r_q        <= {RW{1'b0}};
            c_q        <= {CW{1'b0}};
            wt_rd_q    <= 1'b0;
            wt_addr_q  <= 6'd0;
            pix_rd_q   <= 1'b0;
            pix_addr_q <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pool_idx_q <= 8'd0;
            vld_sr_q   <= '0;
            we_sr_q    <= '0;
            idx_sr_q   <= '0;
            conv_sr_q  <= '0;
            pbuf_sr_q  <= '0;
            pool_sr_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            r_q        <= r_d;
            c_q        <= c_d;
            wt_rd_q    <= wt_rd_d;
            wt_addr_q  <= wt_addr_d;
            pix_rd_q   <= pix_rd_d;
            pix_addr_q <= pix_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pool_idx_q <= pool_idx_d;
            vld_sr_q   <= vld_sr_d;
            we_sr_q    <= we_sr_d;
            idx_sr_q   <= idx_sr_d;
            conv_sr_q  <= conv_sr_d;
            pbuf_sr_q  <= pbuf_sr_d;
            pool_sr_q  <= pool_sr_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wt_rd       = wt_rd_q;
    assign bus.wt_addr     = wt_addr_q;
    assign bus.wt_we       = we_sr_q[RD_LAT-1];
    assign bus.wt_idx      = idx_sr_q[RD_LAT-1];
    assign bus.pix_rd      = pix_rd_q;
    assign bus.pix_addr    = pix_addr_q;
    assign bus.pix_vld     = vld_sr_q[RD_LAT-1];
    assign bus.conv_en     = conv_sr_q[CONV_D-1];
    assign bus.pool_buf_en = pbuf_sr_q[CONV_LAT-1];
    assign bus.pool_en     = pool_sr_q[POOL_D-1];
    assign bus.pool_idx    = pool_idx_q;
endmodule

// File: tb/tb_layer1_sequencer.sv
// Directed bench for layer1_sequencer: a table of image runs checked cycle by
// cycle against an independent timing model, plus reset sequences.
module tb_layer1_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   prints = 0;

    layer1_sequencer_if #(.ADDR_W(14)) bus ();

    layer1_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [13:0] base;
        int          hold;
        logic        drain_pulse;
        int          first_pix;
        int          done_cyc;
        int          n_pix;
        int          n_conv;
        int          n_pool;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s: got %h, expected %h", name, act, exp);
            end
        end
    endtask

    function automatic logic [42:0] raw_outs();
        return {bus.busy, bus.done, bus.wt_rd, bus.wt_addr, bus.wt_we, bus.wt_idx,
                bus.pix_rd, bus.pix_addr, bus.pix_vld, bus.conv_en, bus.pool_buf_en,
                bus.pool_en, bus.pool_idx};
    endfunction

    // Pixel n lies in the 28x28 conv window; optionally also at odd output coords
    function automatic bit in_win(input int n, input bit need_odd);
        int r;
        int c;
        if (n < 0 || n >= 900) return 1'b0;
        r = n / 30;
        c = n % 30;
        if (r < 2 || c < 2) return 1'b0;
        if (need_odd) return (((r - 2) % 2) == 1) && (((c - 2) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int          hist[0:1199];
        bit          seen[900];
        int          k, pix_cnt, conv_cnt, pool_cnt, done_cnt, pool_bad, orphan, map_bad, e_pcount, p;
        logic        e_busy, e_done, e_wt_rd, e_wt_we, e_pix_rd, e_vld, e_conv, e_pbuf, e_pool;
        logic [5:0]  e_wt_addr, e_wt_idx;
        logic [13:0] e_addr;
        logic [7:0]  e_pidx;
        logic [42:0] e_vec, a_vec;
        pix_cnt = 0; conv_cnt = 0; pool_cnt = 0; done_cnt = 0;
        pool_bad = 0; orphan = 0; map_bad = 0; e_pcount = 0;
        for (int i = 0; i < 1200; i++) hist[i] = -1;
        for (int i = 0; i < 900; i++) seen[i] = 1'b0;

        bus.start = 1'b1;
        bus.load_wt = v.load;
        bus.img_base = v.base;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= v.done_cyc + 12; cyc++) begin
            bus.start = (cyc < v.hold) || (v.drain_pulse && cyc == v.first_pix + 901);
            k = cyc - v.first_pix;
            e_busy    = (cyc <= v.done_cyc);
            e_done    = (cyc == v.done_cyc);
            e_wt_rd   = v.load && cyc >= 1 && cyc <= 60;
            e_wt_addr = e_wt_rd ? 6'(cyc - 1) : 6'd0;
            e_wt_we   = v.load && cyc >= 2 && cyc <= 61;
            e_wt_idx  = e_wt_we ? 6'(cyc - 2) : 6'd0;
            e_pix_rd  = (k >= 0 && k < 900);
            e_addr    = e_pix_rd ? (v.base + 14'(k)) : 14'd0;
            e_vld     = (k >= 1 && k <= 900);
            e_conv    = in_win(k - 2, 1'b0);
            e_pbuf    = in_win(k - 3, 1'b0);
            e_pool    = in_win(k - 4, 1'b1);
            e_pidx    = e_pool ? 8'(e_pcount) : 8'd0;
            e_vec = {e_busy, e_done, e_wt_rd, e_wt_addr, e_wt_we, e_wt_idx, e_pix_rd, e_addr,
                     e_vld, e_conv, e_pbuf, e_pool, e_pidx};
            a_vec = {bus.busy, bus.done, bus.wt_rd, (e_wt_rd ? bus.wt_addr : 6'd0), bus.wt_we,
                     (e_wt_we ? bus.wt_idx : 6'd0), bus.pix_rd, (e_pix_rd ? bus.pix_addr : 14'd0),
                     bus.pix_vld, bus.conv_en, bus.pool_buf_en, bus.pool_en,
                     (e_pool ? bus.pool_idx : 8'd0)};
            check($sformatf("v%0d_cyc%0d_outputs", id, cyc), 64'(a_vec), 64'(e_vec));
            if (e_pool) e_pcount++;

            // Scoreboard of (r,c) tags, following pixels actually read
            if (bus.pix_rd) begin
                hist[cyc] = pix_cnt;
                pix_cnt++;
            end
            if (bus.conv_en) begin
                conv_cnt++;
                p = (cyc >= 2) ? hist[cyc - 2] : -1;
                if (p >= 0) seen[p] = 1'b1;
                else orphan++;
            end
            if (bus.pool_en) begin
                pool_cnt++;
                p = (cyc >= 4) ? hist[cyc - 4] : -1;
                if (!in_win(p, 1'b1)) pool_bad++;
            end
            if (bus.done) done_cnt++;
            @(posedge clk); #1;
        end
        for (int n = 0; n < 900; n++) begin
            if (seen[n] != in_win(n, 1'b0)) map_bad++;
        end
        check($sformatf("v%0d_pix_count", id),  64'(pix_cnt),  64'(v.n_pix));
        check($sformatf("v%0d_conv_count", id), 64'(conv_cnt), 64'(v.n_conv));
        check($sformatf("v%0d_pool_count", id), 64'(pool_cnt), 64'(v.n_pool));
        check($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d_conv_map_errors", id), 64'(map_bad + orphan), 64'd0);
        check($sformatf("v%0d_pool_odd_errors", id), 64'(pool_bad), 64'd0);
    endtask

    initial begin
        vecs[0] = '{load: 1'b0, base: 14'd0,     hold: 1, drain_pulse: 1'b0, first_pix: 1,  done_cyc: 904, n_pix: 900, n_conv: 784, n_pool: 196};
        vecs[1] = '{load: 1'b1, base: 14'd0,     hold: 1, drain_pulse: 1'b0, first_pix: 61, done_cyc: 964, n_pix: 900, n_conv: 784, n_pool: 196};
        vecs[2] = '{load: 1'b0, base: 14'd2700,  hold: 1, drain_pulse: 1'b0, first_pix: 1,  done_cyc: 904, n_pix: 900, n_conv: 784, n_pool: 196};
        vecs[3] = '{load: 1'b0, base: 14'd0,     hold: 5, drain_pulse: 1'b1, first_pix: 1,  done_cyc: 904, n_pix: 900, n_conv: 784, n_pool: 196};
        vecs[4] = '{load: 1'b0, base: 14'd16380, hold: 1, drain_pulse: 1'b0, first_pix: 1,  done_cyc: 904, n_pix: 900, n_conv: 784, n_pool: 196};

        bus.start = 1'b0;
        bus.load_wt = 1'b0;
        bus.img_base = 14'd0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(raw_outs()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 64'(raw_outs()), 64'd0);

        // Abort mid-STREAM at cycle 400
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (399) begin
            @(posedge clk); #1;
        end
        check("pre_abort_pix_rd", 64'(bus.pix_rd), 64'd1);
        check("pre_abort_pix_addr", 64'(bus.pix_addr), 64'd399);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'(raw_outs()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("abort_hold%0d", i), 64'(raw_outs()), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_abort_idle%0d", i), 64'(raw_outs()), 64'd0);
        end

        // Table of full-image runs (entry 0 is the fresh start after the abort)
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
